instruction_fetch_memory: RTL and testbench

Parametrised successor to the single-port simulation instruction store. It returns a FETCH_WIDTH-wide window of consecutive instructions per request through a registered valid/ready read path. After every reset it self-initialises all words to NOP. It also provides an auto-incrementing debug burst-load port for benches. It sits between the fetch stage and the instruction address generator; the fetch stage consumes windows for FENCE and look-ahead handling.

---
 rtl/instruction_fetch_memory.sv | 166 ++++++++++++++++
 tb/tb_instruction_fetch_memory.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_memory.sv
// Instruction store returning FETCH_WIDTH-wide windows over a registered valid/ready path.
// Self-fills with NOP_FILL after reset; optional per-word parity under INSTR_MEM_PARITY_EN.
module instruction_fetch_memory #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = XLEN / 2,
    parameter int unsigned MEMORY_DEPTH_LOG2  = 5,
    parameter int unsigned FETCH_WIDTH        = 3,
    parameter logic [INSTRUCTION_LENGTH-1:0] NOP_FILL = INSTRUCTION_LENGTH'(32'h00000013)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [MEMORY_DEPTH_LOG2-1:0]              req_addr,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [FETCH_WIDTH*INSTRUCTION_LENGTH-1:0] rsp_instr,
    output logic [MEMORY_DEPTH_LOG2-1:0]              rsp_addr,
    input  logic                                      dbg_wr_en,
    input  logic                                      dbg_wr_start,
    input  logic [MEMORY_DEPTH_LOG2-1:0]              dbg_addr,
    input  logic [INSTRUCTION_LENGTH-1:0]             dbg_instr,
    input  logic                                      dbg_parity_inject,
    output logic                                      init_done,
    output logic                                      parity_err
);

    localparam int unsigned DEPTH = 2 ** MEMORY_DEPTH_LOG2;
    localparam int unsigned AW    = MEMORY_DEPTH_LOG2;
    localparam int unsigned IL    = INSTRUCTION_LENGTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t state, state_next;

    logic [IL-1:0] mem [DEPTH];
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] dbg_ptr, dbg_ptr_next;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IL-1:0] wr_data;

    logic                      accept;
    logic [FETCH_WIDTH*IL-1:0] window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            dbg_ptr  <= '0;
        end else begin
            state   <= state_next;
            dbg_ptr <= dbg_ptr_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic wr_par;
    logic window_perr;
`else
    logic unused_parity_inject;
    assign unused_parity_inject = dbg_parity_inject;
`endif

    // The single write port is owned by the init sweep in INIT and by the debug port in READY.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = init_cnt;
        wr_data      = NOP_FILL;
        dbg_ptr_next = dbg_ptr;
`ifdef INSTR_MEM_PARITY_EN
        wr_par       = ^NOP_FILL;
`endif
        case (state)
            ST_INIT: begin
                wr_en = 1'b1;
                if (init_cnt == '1) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                req_ready = !rsp_valid || rsp_ready;
                wr_data   = dbg_instr;
`ifdef INSTR_MEM_PARITY_EN
                wr_par    = (^dbg_instr) ^ dbg_parity_inject;
`endif
                if (dbg_wr_start) begin
                    wr_addr      = dbg_addr;
                    dbg_ptr_next = dbg_addr;
                end else begin
                    wr_addr = dbg_ptr;
                end
                if (dbg_wr_en) begin
                    wr_en        = 1'b1;
                    dbg_ptr_next = wr_addr + 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
`ifdef INSTR_MEM_PARITY_EN
            par_mem[wr_addr] <= wr_par;
`endif
        end
    end

    // Slot addresses are formed at AW bits so the window wraps around the top of memory.
    always_comb begin
        logic [AW-1:0] slot_addr;
        window = '0;
`ifdef INSTR_MEM_PARITY_EN
        window_perr = 1'b0;
`endif
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            slot_addr = req_addr + AW'(k);
            window[k*IL +: IL] = mem[slot_addr];
`ifdef INSTR_MEM_PARITY_EN
            window_perr = window_perr | ((^mem[slot_addr]) != par_mem[slot_addr]);
`endif
        end
    end

    assign accept    = req_valid && req_ready;
    assign init_done = (state == ST_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_instr <= window;
            rsp_addr  <= req_addr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (accept) begin
            parity_err <= window_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed self-checking bench for instruction_fetch_memory (default parameters, 32 words, 3-wide window).
module tb_instruction_fetch_memory;

    localparam int unsigned AW = 5;
    localparam int unsigned IL = 32;
    localparam int unsigned FW = 3;
    localparam logic [FW*IL-1:0] NOP3 = {3{32'h00000013}};
`ifdef INSTR_MEM_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [FW*IL-1:0] rsp_instr;
    logic [AW-1:0]    rsp_addr;
    logic             dbg_wr_en;
    logic             dbg_wr_start;
    logic [AW-1:0]    dbg_addr;
    logic [IL-1:0]    dbg_instr;
    logic             dbg_parity_inject;
    logic             init_done;
    logic             parity_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_memory #(
        .XLEN              (64),
        .MEMORY_DEPTH_LOG2 (AW),
        .FETCH_WIDTH       (FW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_instr         (rsp_instr),
        .rsp_addr          (rsp_addr),
        .dbg_wr_en         (dbg_wr_en),
        .dbg_wr_start      (dbg_wr_start),
        .dbg_addr          (dbg_addr),
        .dbg_instr         (dbg_instr),
        .dbg_parity_inject (dbg_parity_inject),
        .init_done         (init_done),
        .parity_err        (parity_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i < 32) check("init_busy", {init_done, req_ready}, 2'b00);
            else        check("init_done", {init_done, req_ready}, 2'b11);
        end
    endtask

    task automatic dbg_write(input logic start, input logic [AW-1:0] addr,
                             input logic [IL-1:0] data, input logic inject);
        dbg_wr_en         = 1'b1;
        dbg_wr_start      = start;
        dbg_addr          = addr;
        dbg_instr         = data;
        dbg_parity_inject = inject;
        tick();
        dbg_wr_en         = 1'b0;
        dbg_wr_start      = 1'b0;
        dbg_parity_inject = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic [FW*IL-1:0] exp, input logic perr);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = addr;
        check({tag, "_rdy"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_instr"}, rsp_instr, exp);
        check({tag, "_addr"}, rsp_addr, addr);
        check({tag, "_perr"}, parity_err, perr);
        tick();
        check({tag, "_drain"}, rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        dbg_wr_en = 1'b0; dbg_wr_start = 1'b0; dbg_addr = '0; dbg_instr = '0;
        dbg_parity_inject = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_instr", rsp_instr, '0);
        check("rst_rsp_addr", rsp_addr, '0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        rst_n = 1'b1;
        wait_init();

        read_check("nop0", 5'd0, NOP3, 1'b0);

        dbg_write(1'b1, 5'd4, 32'hAAAA0001, 1'b0);
        dbg_write(1'b0, 5'd0, 32'hAAAA0002, 1'b0);
        dbg_write(1'b0, 5'd0, 32'hAAAA0003, 1'b0);
        read_check("burst", 5'd4, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001}, 1'b0);

        // Pointer wraps 31 -> 0 on the third write.
        dbg_write(1'b1, 5'd30, 32'h11111111, 1'b0);
        dbg_write(1'b0, 5'd0, 32'h22222222, 1'b0);
        dbg_write(1'b0, 5'd0, 32'h33333333, 1'b0);
        read_check("wrap", 5'd30, {32'h33333333, 32'h22222222, 32'h11111111}, 1'b0);

        dbg_wr_start = 1'b1; dbg_addr = 5'd20;
        tick();
        dbg_wr_start = 1'b0;
        dbg_write(1'b0, 5'd0, 32'h55555555, 1'b0);
        read_check("ptr_load", 5'd19, {32'h00000013, 32'h55555555, 32'h00000013}, 1'b0);

        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd4;
        tick();
        check("bp_valid", rsp_valid, 1'b1);
        check("bp_addr", rsp_addr, 5'd4);
        check("bp_instr", rsp_instr, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001});
        check("bp_req_ready", req_ready, 1'b0);
        req_addr = 5'd8;
        tick();
        check("bp_hold_addr", rsp_addr, 5'd4);
        check("bp_hold_instr", rsp_instr, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001});
        check("bp_hold_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("bp_next_valid", rsp_valid, 1'b1);
        check("bp_next_addr", rsp_addr, 5'd8);
        check("bp_next_instr", rsp_instr, NOP3);
        tick();
        check("bp_drain", rsp_valid, 1'b0);

        dbg_wr_en = 1'b1; dbg_wr_start = 1'b1; dbg_addr = 5'd10; dbg_instr = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 5'd10;
        tick();
        dbg_wr_en = 1'b0; dbg_wr_start = 1'b0; req_valid = 1'b0;
        check("col_old", rsp_instr, NOP3);
        tick();
        read_check("col_new", 5'd10, {32'h00000013, 32'h00000013, 32'hDEADBEEF}, 1'b0);

        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd4;
        tick();
        req_valid = 1'b0;
        check("mid_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_init", {init_done, req_ready}, 2'b00);
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        wait_init();
        read_check("reinit", 5'd4, NOP3, 1'b0);

        dbg_write(1'b1, 5'd5, 32'h12345678, 1'b1);
        read_check("par_bad", 5'd4, {32'h00000013, 32'h12345678, 32'h00000013}, PAR_ON);
        read_check("par_good", 5'd6, NOP3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
